// File: rtl/tof_frame_writer.sv
// ToF frame writer: collects 64-zone frames from up to 8 sensors into BRAM,
// raises drdy once every enabled sensor has delivered a full frame, and holds
// the buffer stable until the reader acknowledges.
module tof_frame_writer #(
  parameter int          DATA_W    = 16,
  parameter logic [7:0]  SENS_MASK = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_sens,
  input  logic [5:0]        in_zone,
  input  logic [DATA_W-1:0] in_data,
  output logic              bram_we,
  output logic [8:0]        bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  output logic              drdy,
  input  logic              frame_ack,
  output logic              seq_err,
  output logic [7:0]        drop_cnt,
  output logic [7:0]        frame_cnt
);

  typedef enum logic [1:0] {COLLECT, FLUSH, READY} state_t;

  state_t     state, next_state;
  logic [7:0] done_mask;
  logic [5:0] exp_zone [8];

  logic       accept;
  logic       active;
  logic       in_order;
  logic       zone_first;
  logic       zone_last_hit;
  logic       do_write;
  logic       do_err;
  logic       do_drop;
  logic       frame_done;
  logic [7:0] new_done;

  // Classify the current beat against the per-sensor progress trackers.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    new_done      = done_mask;
    accept        = in_valid & in_ready;
    active        = SENS_MASK[in_sens] & ~done_mask[in_sens];
    in_order      = (in_zone == exp_zone[in_sens]);
    zone_first    = (in_zone == 6'd0);
    zone_last_hit = accept & active & in_order & (in_zone == 6'd63);
    do_write      = accept & active & (in_order | zone_first);
    do_err        = accept & active & ~in_order;
    do_drop       = accept & ~(active & (in_order | zone_first));
    if (zone_last_hit) new_done[in_sens] = 1'b1;
    frame_done    = zone_last_hit & ((new_done & SENS_MASK) == SENS_MASK);
  end

  // Next-state logic: collect until complete, flush the last write, then hold.
  always_comb begin
    next_state = state;
    case (state)
      COLLECT: if (frame_done) next_state = FLUSH;
      FLUSH:   next_state = READY;
      READY:   if (frame_ack) next_state = COLLECT;
      default: next_state = COLLECT;
    endcase
  end

  // State register plus registered handshake/status outputs derived from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      in_ready  <= 1'b0;
      drdy      <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state    <= next_state;
      in_ready <= (next_state == COLLECT);
      drdy     <= (next_state == READY);
      if (state == FLUSH) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // Per-sensor expected zone and completion tracking; cleared when the frame is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_mask <= 8'd0;
      // NOTE: the tracker array is small register state, so it is reset; the BRAM itself is not.
      for (int s = 0; s < 8; s++) exp_zone[s] <= 6'd0;
    end else if (state == READY && frame_ack) begin
      done_mask <= 8'd0;
      for (int s = 0; s < 8; s++) exp_zone[s] <= 6'd0;
    end else if (accept && active) begin
      done_mask <= new_done;
      if (in_order)        exp_zone[in_sens] <= in_zone + 6'd1;  // 63 wraps to 0
      else if (zone_first) exp_zone[in_sens] <= 6'd1;
      else                 exp_zone[in_sens] <= 6'd0;
    end
  end

  // Registered write port, sequence-error pulse and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bram_we    <= 1'b0;
      bram_addr  <= 9'd0;
      bram_wdata <= '0;
      seq_err    <= 1'b0;
      drop_cnt   <= 8'd0;
    end else begin
      bram_we <= do_write;
      seq_err <= do_err;
      if (do_write) begin
        bram_addr  <= {in_sens, in_zone};
        bram_wdata <= in_data;
      end
      if (do_drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_tof_frame_writer.sv
// Scoreboard bench for tof_frame_writer: two instances (all sensors enabled,
// sensor 0 only) share the stimulus; sel picks which one is driven and checked.
module tb_tof_frame_writer;

  localparam int DATA_W = 16;

  typedef struct {
    logic       we;
    logic [8:0] addr;
    logic [15:0] data;
    logic       err;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [2:0]        in_sens = '0;
  logic [5:0]        in_zone = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              frame_ack = 1'b0;
  logic              sel = 1'b0;

  logic              a_ready, a_we, a_drdy, a_err;
  logic [8:0]        a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic [7:0]        a_drop, a_frames;
  logic              b_ready, b_we, b_drdy, b_err;
  logic [8:0]        b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic [7:0]        b_drop, b_frames;

  logic              m_ready, m_we, m_drdy, m_err;
  logic [8:0]        m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [7:0]        m_drop, m_frames;

  int   tests = 0;
  int   fails = 0;
  int   wr_cnt = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  tof_frame_writer #(.DATA_W(DATA_W), .SENS_MASK(8'hFF)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_ready),
    .in_sens(in_sens), .in_zone(in_zone), .in_data(in_data),
    .bram_we(a_we), .bram_addr(a_addr), .bram_wdata(a_wdata),
    .drdy(a_drdy), .frame_ack(frame_ack), .seq_err(a_err),
    .drop_cnt(a_drop), .frame_cnt(a_frames));

  tof_frame_writer #(.DATA_W(DATA_W), .SENS_MASK(8'h01)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_ready),
    .in_sens(in_sens), .in_zone(in_zone), .in_data(in_data),
    .bram_we(b_we), .bram_addr(b_addr), .bram_wdata(b_wdata),
    .drdy(b_drdy), .frame_ack(frame_ack), .seq_err(b_err),
    .drop_cnt(b_drop), .frame_cnt(b_frames));

  assign m_ready  = sel ? b_ready  : a_ready;
  assign m_we     = sel ? b_we     : a_we;
  assign m_addr   = sel ? b_addr   : a_addr;
  assign m_wdata  = sel ? b_wdata  : a_wdata;
  assign m_drdy   = sel ? b_drdy   : a_drdy;
  assign m_err    = sel ? b_err    : a_err;
  assign m_drop   = sel ? b_drop   : a_drop;
  assign m_frames = sel ? b_frames : a_frames;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every write or seq_err pulse of the selected instance must match the next expectation.
  always @(negedge clk) begin
    if (rst_n && (m_we || m_err)) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_event", {m_we, m_err}, 2'b00);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_we", m_we, e.we);
        check("sb_err", m_err, e.err);
        if (e.we) begin
          check("sb_addr", m_addr, e.addr);
          check("sb_wdata", m_wdata, e.data);
        end
      end
      if (m_we) wr_cnt++;
    end
  end

  task automatic do_reset();
    in_valid  = 1'b0;
    frame_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    check("reset_in_ready", m_ready, 1'b0);
    check("reset_drdy", m_drdy, 1'b0);
    rst_n = 1'b1;
    wr_cnt = 0;
  endtask

  // Drive one beat; expectations are queued only when a write or error is predicted.
  task automatic send(input logic [2:0] s, input logic [5:0] z, input logic we, input logic err);
    int n;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_sens  = s;
    in_zone  = z;
    in_data  = 16'({s, z});
    if (we || err) begin
      e.we = we; e.addr = {s, z}; e.data = 16'({s, z}); e.err = err;
      sb.push_back(e);
    end
    n = 0;
    while (!m_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("ready_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_range(input logic [2:0] s, input int lo, input int hi);
    for (int z = lo; z <= hi; z++) send(s, 6'(z), 1'b1, 1'b0);
  endtask

  // After the final accept: write still landing, then drdy the cycle after.
  task automatic expect_done(input string tag);
    @(negedge clk);
    check({tag, "_drdy_early"}, m_drdy, 1'b0);
    check({tag, "_ready_drop"}, m_ready, 1'b0);
    @(negedge clk);
    check({tag, "_drdy"}, m_drdy, 1'b1);
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic ack();
    @(negedge clk);
    frame_ack = 1'b1;
    @(posedge clk);
    #1 frame_ack = 1'b0;
    @(negedge clk);
    check("ack_drdy_low", m_drdy, 1'b0);
    check("ack_ready_high", m_ready, 1'b1);
  endtask

  initial begin
    // Nominal frame, all eight sensors.
    sel = 1'b0;
    do_reset();
    for (int s = 0; s < 8; s++) send_range(3'(s), 0, 63);
    expect_done("nominal");
    check("nominal_writes", wr_cnt, 512);
    check("nominal_frame_cnt", m_frames, 1);
    check("nominal_drop_cnt", m_drop, 0);

    // Hold the buffer while the source keeps pushing, then acknowledge.
    @(negedge clk);
    in_valid = 1'b1;
    in_sens = 3'd0; in_zone = 6'd0; in_data = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_ready", m_ready, 1'b0);
      check("hold_we", m_we, 1'b0);
      check("hold_drdy", m_drdy, 1'b1);
    end
    in_valid = 1'b0;
    ack();

    // Asynchronous reset in the middle of sensor 1, mid clock cycle.
    send_range(3'd0, 0, 63);
    send_range(3'd1, 0, 29);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("areset_in_ready", m_ready, 1'b0);
    check("areset_we", m_we, 1'b0);
    check("areset_addr", m_addr, 9'd0);
    check("areset_wdata", m_wdata, 16'd0);
    check("areset_drdy", m_drdy, 1'b0);
    check("areset_err", m_err, 1'b0);
    check("areset_frame_cnt", m_frames, 8'd0);
    check("areset_drop_cnt", m_drop, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wr_cnt = 0;
    for (int s = 0; s < 8; s++) send_range(3'(s), 0, 63);
    expect_done("post_reset");
    check("post_reset_frame_cnt", m_frames, 1);
    check("post_reset_writes", wr_cnt, 512);

    // Sequence error, resync and duplicate from a finished sensor.
    do_reset();
    send_range(3'd2, 0, 2);
    send(3'd2, 6'd5, 1'b0, 1'b1);
    @(negedge clk);
    check("seq_drop_cnt", m_drop, 1);
    send(3'd2, 6'd0, 1'b1, 1'b0);       // addr 9'h080, no error
    send_range(3'd2, 1, 63);            // exp_zone restarted
    send_range(3'd3, 0, 9);
    send(3'd3, 6'd0, 1'b1, 1'b1);       // resync: error + write to 9'h0C0
    send_range(3'd0, 0, 63);
    send(3'd0, 6'd5, 1'b0, 1'b0);       // duplicate from done sensor
    @(negedge clk);
    check("dup_drop_cnt", m_drop, 2);
    send_range(3'd1, 0, 63);
    for (int s = 4; s < 8; s++) send_range(3'(s), 0, 63);
    send_range(3'd3, 1, 62);
    @(negedge clk);
    check("resync_not_done_drdy", m_drdy, 1'b0);
    check("resync_not_done_ready", m_ready, 1'b1);
    send(3'd3, 6'd63, 1'b1, 1'b0);
    expect_done("resync");
    check("resync_frame_cnt", m_frames, 1);
    ack();

    // Sensor 0 only: other sensors dropped, frame completes on sensor 0.
    sel = 1'b1;
    do_reset();
    send(3'd4, 6'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("mask_drop_cnt", m_drop, 1);
    send_range(3'd0, 0, 63);
    expect_done("mask_frame1");
    ack();
    send_range(3'd0, 0, 63);
    expect_done("mask_frame2");
    check("mask_frame_cnt", m_frames, 2);
    check("mask_drop_cnt_final", m_drop, 1);
    ack();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
